// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the 16-bit, 16-register core, with load-use and
// branch-operand interlock, multicycle-EX hold and a saturating bubble counter.
module id_ex_stage #(
    parameter int DATA_W = 16,
    parameter int REG_W  = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              id_valid,
    input  logic [REG_W-1:0]  id_op1,
    input  logic [REG_W-1:0]  id_op2,
    input  logic              id_uses_op2,
    input  logic [DATA_W-1:0] id_rd1,
    input  logic [DATA_W-1:0] id_rd2,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [1:0]        id_regwrite,
    input  logic              id_memread,
    input  logic              id_memwrite,
    input  logic [3:0]        id_alu_ctrl,
    input  logic              id_branch,
    input  logic              ex_busy,
    input  logic              flush,
    output logic              ex_valid,
    output logic [REG_W-1:0]  ex_op1,
    output logic [REG_W-1:0]  ex_op2,
    output logic [DATA_W-1:0] ex_rd1,
    output logic [DATA_W-1:0] ex_rd2,
    output logic [DATA_W-1:0] ex_imm,
    output logic [1:0]        ex_regwrite,
    output logic              ex_muxc,
    output logic              ex_memwrite,
    output logic [3:0]        ex_alu_ctrl,
    output logic              id_hold,
    output logic [15:0]       stall_count
);

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        BUB2 = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_valid;
    logic [REG_W-1:0]    r_op1;
    logic [REG_W-1:0]    r_op2;
    logic [DATA_W-1:0]   r_rd1;
    logic [DATA_W-1:0]   r_rd2;
    logic [DATA_W-1:0]   r_imm;
    logic [1:0]          r_regwrite;
    logic                r_muxc;
    logic                r_memwrite;
    logic [3:0]          r_alu_ctrl;
    logic [15:0]         r_stall_count;

    logic                w_hit_op1;
    logic                w_hit_op2;
    logic                w_load_haz;
    logic                w_br_haz;
    logic                w_bubble;
    logic                w_capture;
    logic                w_hold;
    logic                w_stall_inc;
    logic [1:0]          w_rw_cap;

    // A mul/div (regwrite 11) also writes R0, so R0 readers see a hit too.
    function automatic logic dest_hit(input logic             valid,
                                      input logic [1:0]       rw,
                                      input logic [REG_W-1:0] dst,
                                      input logic [REG_W-1:0] r);
        logic wr_op1;
        logic wr_r0;
        wr_op1   = (rw == 2'b01) || (rw == 2'b11);
        wr_r0    = (rw == 2'b11) && (r == {REG_W{1'b0}});
        dest_hit = valid && ((wr_op1 && (dst == r)) || wr_r0);
    endfunction

    assign w_hit_op1  = dest_hit(r_valid, r_regwrite, r_op1, id_op1);
    assign w_hit_op2  = dest_hit(r_valid, r_regwrite, r_op1, id_op2);
    assign w_load_haz = r_muxc && id_valid && (w_hit_op1 || (id_uses_op2 && w_hit_op2));
    assign w_br_haz   = id_valid && id_branch && w_hit_op1 && !r_muxc;
    assign w_rw_cap   = (id_valid && (id_regwrite != 2'b10)) ? id_regwrite : 2'b00;

    // Interlock decision: flush, then EX hold, then bubble, else capture.
    always_comb begin
        w_bubble    = 1'b0;
        w_capture   = 1'b0;
        w_hold      = 1'b0;
        w_stall_inc = 1'b0;
        w_state_nxt = r_state;
        if (flush) begin
            w_bubble    = 1'b1;
            w_state_nxt = RUN;
        end else if (ex_busy) begin
            w_hold = 1'b1;
        end else if ((r_state == BUB2) || w_load_haz || w_br_haz) begin
            w_bubble    = 1'b1;
            w_hold      = 1'b1;
            w_stall_inc = 1'b1;
            case (r_state)
                RUN:     w_state_nxt = (w_load_haz && id_branch) ? BUB2 : RUN;
                BUB2:    w_state_nxt = RUN;
                default: w_state_nxt = RUN;
            endcase
        end else begin
            w_capture = 1'b1;
        end
    end

    assign id_hold = reset_n & w_hold;

    // Interlock state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ID/EX payload register: bubble, capture or hold.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid    <= 1'b0;
            r_op1      <= {REG_W{1'b0}};
            r_op2      <= {REG_W{1'b0}};
            r_rd1      <= {DATA_W{1'b0}};
            r_rd2      <= {DATA_W{1'b0}};
            r_imm      <= {DATA_W{1'b0}};
            r_regwrite <= 2'b00;
            r_muxc     <= 1'b0;
            r_memwrite <= 1'b0;
            r_alu_ctrl <= 4'h0;
        end else if (w_bubble) begin
            r_valid    <= 1'b0;
            r_op1      <= {REG_W{1'b0}};
            r_op2      <= {REG_W{1'b0}};
            r_rd1      <= {DATA_W{1'b0}};
            r_rd2      <= {DATA_W{1'b0}};
            r_imm      <= {DATA_W{1'b0}};
            r_regwrite <= 2'b00;
            r_muxc     <= 1'b0;
            r_memwrite <= 1'b0;
            r_alu_ctrl <= 4'h0;
        end else if (w_capture) begin
            r_valid    <= id_valid;
            r_op1      <= id_op1;
            r_op2      <= id_op2;
            r_rd1      <= id_rd1;
            r_rd2      <= id_rd2;
            r_imm      <= id_imm;
            r_regwrite <= w_rw_cap;
            r_muxc     <= id_valid & id_memread;
            r_memwrite <= id_valid & id_memwrite;
            r_alu_ctrl <= id_alu_ctrl;
        end else begin
            r_valid    <= r_valid;
            r_op1      <= r_op1;
            r_op2      <= r_op2;
            r_rd1      <= r_rd1;
            r_rd2      <= r_rd2;
            r_imm      <= r_imm;
            r_regwrite <= r_regwrite;
            r_muxc     <= r_muxc;
            r_memwrite <= r_memwrite;
            r_alu_ctrl <= r_alu_ctrl;
        end
    end

    // Saturating bubble counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stall_count <= 16'h0000;
        end else if (w_stall_inc && (r_stall_count != 16'hFFFF)) begin
            r_stall_count <= r_stall_count + 16'h0001;
        end else begin
            r_stall_count <= r_stall_count;
        end
    end

    assign ex_valid    = r_valid;
    assign ex_op1      = r_op1;
    assign ex_op2      = r_op2;
    assign ex_rd1      = r_rd1;
    assign ex_rd2      = r_rd2;
    assign ex_imm      = r_imm;
    assign ex_regwrite = r_regwrite;
    assign ex_muxc     = r_muxc;
    assign ex_memwrite = r_memwrite;
    assign ex_alu_ctrl = r_alu_ctrl;
    assign stall_count = r_stall_count;

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register with load-use and branch-operand hazard interlock for the 16-bit, 16-register core. It captures decoded operands and control from ID and presents them to EX and to the forwarding unit, which consumes `ex_op1`, `ex_op2` and `ex_regwrite`. When forwarding cannot cover a dependency, it inserts bubbles and holds PC and IF/ID. It also holds its contents while a multicycle EX operation is busy.

## Interface
- DATA_W, 16, operand/immediate width
- REG_W, 4, register-specifier width
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- id_valid  in  1  ID holds a real instruction
- id_op1, id_op2  in  REG_W  ID register specifiers (op1 is also the destination)
- id_uses_op2  in  1  instruction reads op2
- id_rd1, id_rd2, id_imm  in  DATA_W  register-file read data and extended immediate
- id_regwrite  in  2  00 none, 01 write op1, 11 write op1 and R0 (mul/div); 10 treated as 00
- id_memread  in  1  load; becomes `ex_muxc`
- id_memwrite  in  1  store
- id_alu_ctrl  in  4  ALU function
- id_branch  in  1  branch resolved in ID; reads op1
- ex_busy  in  1  EX multicycle unit not done
- flush  in  1  kill the instruction entering EX
- ex_valid, ex_op1, ex_op2, ex_rd1, ex_rd2, ex_imm, ex_regwrite, ex_muxc, ex_memwrite, ex_alu_ctrl  out  registered copies of the id_* fields
- id_hold  out  1  PC and IF/ID must not advance this cycle
- stall_count  out  16  saturating count of bubble cycles inserted

## Operation
- **Destination match.** `dest_hit(r)` = ex_valid & ((ex_regwrite ∈ {01,11} & ex_op1==r) | (ex_regwrite==11 & r==0)).
- **load_haz.** ex_muxc & id_valid & (dest_hit(id_op1) | (id_uses_op2 & dest_hit(id_op2))).
- **br_haz.** id_valid & id_branch & dest_hit(id_op1) & !ex_muxc.
- **FSM.**
  - States: RUN, BUB2.
  - RUN with load_haz & id_branch: insert bubble, go to BUB2.
  - RUN with load_haz or br_haz (otherwise): insert one bubble, stay in RUN. The following cycle re-evaluates with ex_valid=0.
  - BUB2: insert bubble unconditionally, return to RUN.
- **Bubble.** ex_valid, ex_regwrite, ex_muxc and ex_memwrite load 0. Data and specifier fields load 0. id_hold=1.
- **Per-edge priority, highest first:**
  1. reset: all outputs 0, state RUN, stall_count 0.
  2. flush: load bubble, state to RUN, id_hold=0. Flush overrides ex_busy.
  3. ex_busy: all ex_* hold, state holds, id_hold=1, stall_count unchanged.
  4. Hazard or BUB2: load bubble, id_hold=1, stall_count+1.
  5. Otherwise: capture all id_* fields (ex_valid=id_valid), id_hold=0.
- **id_valid=0.** Captures as a normal instruction with ex_valid=0. Control fields pass through masked to 0.
- **stall_count.** Saturates at 16'hFFFF and does not wrap.
- **id_hold during reset.** Forced to 0 while reset_n is low.

## Timing
- ID→EX latency is 1 cycle, with all ex_* registered.
- id_hold is combinational from the current ex_* registers, state, id_* inputs, ex_busy and flush, all in the same cycle. Upstream samples it at the same edge.
- A load followed by a dependent ALU op gives 1 bubble; the forwarding unit then supplies the value from MEM (muxc).
- A dependent branch after an ALU op gives 1 bubble.
- A dependent branch after a load gives 2 bubbles.
- A reset mid-stall aborts BUB2; the first post-reset edge is a normal capture.
- ex_busy asserted in BUB2 freezes the FSM; the remaining bubble is inserted after ex_busy drops.
- Simultaneous flush and hazard: flush wins and no stall_count increment occurs.

## Test plan
- Reset with id_* nonzero → all ex_*=0, id_hold=0, stall_count=0. Release, then one edge with id_op1=3, id_rd1=16'h1234, id_regwrite=01 → ex_op1=3, ex_rd1=16'h1234, ex_valid=1.
- Load to R5, then `add` reading op2=R5 with id_uses_op2=1 → id_hold=1 for exactly 1 cycle, one bubble, add enters EX on the 2nd edge, stall_count=1. Same pair with id_uses_op2=0 and op1≠5 → no stall.
- Load to R2, then branch on R2 → id_hold high for 2 cycles, state RUN→BUB2→RUN, stall_count=2. Branch on an R2 written by an ALU op → 1 bubble.
- Mul with regwrite=11, op1=7, followed by an instruction reading R0 and a branch on R0 → R0 hit detected and 1 bubble. regwrite=10 → no hit.
- ex_busy held 4 cycles → ex_* unchanged, id_hold=1, stall_count unchanged. Flush asserted in the 3rd cycle → ex_valid=0 next edge, id_hold=0.
- Force stall_count to 16'hFFFE, then 3 bubbles → stall_count stays at 16'hFFFF. Assert reset_n low in BUB2 → asynchronous clear, first capture after release is normal.
